// File: rtl/ram_led_top.sv
// ram_led_top: board demo. Switches address a 1024x16 preloaded ROM and the
// registered read data drives the LEDs. The serial line is looped straight back.
module ram_led_top #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  tx,
    input  logic [15:0]           sw,
    output logic [DATA_WIDTH-1:0] led
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Upper switches are deliberately ignored so they can never alias into the address.
    logic unused_sw;
    assign unused_sw = ^sw[15:ADDR_WIDTH];

    // Fixed contents. A case table in a clocked read with a registered output
    // keeps the array inferable as a preloaded block ROM; unlisted words are 0.
    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        case (a)
            ADDR_WIDTH'(0): w = 16'b0000000000000001;
            ADDR_WIDTH'(1): w = 16'b1010101010101010;
            ADDR_WIDTH'(2): w = 16'b0101010101010101;
            ADDR_WIDTH'(3): w = 16'b1111111111111111;
            ADDR_WIDTH'(4): w = 16'b1111000011110000;
            ADDR_WIDTH'(5): w = 16'b0000111100001111;
            ADDR_WIDTH'(6): w = 16'b1100110011001100;
            ADDR_WIDTH'(7): w = 16'b0011001100110011;
            ADDR_WIDTH'(8): w = 16'b0000000000000010;
            ADDR_WIDTH'(9): w = 16'b0000000000000100;
            default:        w = '0;
        endcase
        return w;
    endfunction

    // Serial loopback: pure wire, no register, independent of reset.
    assign tx = rx;

    // Three-stage read pipeline: address register, ROM output register, LED register.
    // Reset clears the pipeline only; the ROM contents are constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            led    <= '0;
        end else begin
            addr_q <= sw[ADDR_WIDTH-1:0];
            data_q <= rom_word(addr_q);
            led    <= data_q;
        end
    end

endmodule

// File: tb/tb_ram_led_top.sv
// Directed bench for ram_led_top: loopback, async reset, streaming reads,
// latency exactness and address range / unused switch bits.
module tb_ram_led_top;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        tx;
    logic [15:0] sw;
    logic [15:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    ram_led_top #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .tx    (tx),
        .sw    (sw),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written expected ROM contents.
    function automatic logic [15:0] exp_word(input int a);
        case (a)
            0: return 16'h0001;
            1: return 16'hAAAA;
            2: return 16'h5555;
            3: return 16'hFFFF;
            4: return 16'hF0F0;
            5: return 16'h0F0F;
            6: return 16'hCCCC;
            7: return 16'h3333;
            8: return 16'h0002;
            9: return 16'h0004;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge, toggle rx and confirm the loopback.
    // On return we are 2 time units after the edge, well away from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
        rx = ~rx;
        #1;
        chk("loopback", {31'd0, tx}, {31'd0, rx});
    endtask

    int addr_seq [30];

    initial begin
        rst_n = 1'b0;
        rx    = 1'b0;
        sw    = 16'h0000;

        // Reset state and loopback while held in reset.
        repeat (3) tick();
        chk("reset_led", {16'd0, led}, 32'h0);
        rx = 1'b1;
        #1;
        chk("loopback_noclk", {31'd0, tx}, 32'd1);

        // Streaming read: release with sw=0, then 0..9 three times, one per clock.
        for (int i = 0; i < 30; i++) addr_seq[i] = i % 10;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sw = (i < 30) ? 16'(addr_seq[i]) : 16'h0000;
            tick();
            if (i == 0)
                chk("stream_e0", {16'd0, led}, 32'h0);
            else if (i == 1)
                chk("stream_e1", {16'd0, led}, {16'd0, exp_word(0)});
            else
                chk($sformatf("stream_a%0d", addr_seq[i-2]), {16'd0, led},
                    {16'd0, exp_word(addr_seq[i-2])});
        end

        // Latency exactness: 4,4,4,4,5,4,4,4,4.
        sw = 16'd4;
        repeat (4) tick();
        chk("lat_hold4", {16'd0, led}, 32'h0000F0F0);
        sw = 16'd5;
        tick();                      // edge k samples 5
        chk("lat_k", {16'd0, led}, 32'h0000F0F0);
        sw = 16'd4;
        tick();                      // edge k+1
        chk("lat_k1", {16'd0, led}, 32'h0000F0F0);
        tick();                      // edge k+2
        chk("lat_k2", {16'd0, led}, 32'h00000F0F);
        tick();                      // edge k+3
        chk("lat_k3", {16'd0, led}, 32'h0000F0F0);
        tick();
        chk("lat_k4", {16'd0, led}, 32'h0000F0F0);

        // Unused upper switch bits and address range.
        sw = 16'hFC00;
        repeat (3) tick();
        chk("upper_bits_fc00", {16'd0, led}, 32'h00000001);
        sw = 16'hFC03;
        repeat (3) tick();
        chk("upper_bits_fc03", {16'd0, led}, 32'h0000FFFF);
        sw = 16'd10;
        repeat (3) tick();
        chk("addr_10", {16'd0, led}, 32'h0);
        sw = 16'd1023;
        repeat (3) tick();
        chk("addr_1023", {16'd0, led}, 32'h0);
        sw = 16'h0409;               // bit 10 set must not alias to 1033
        repeat (3) tick();
        chk("addr_0409", {16'd0, led}, 32'h00000004);

        // Mid-run asynchronous reset with led non-zero.
        sw = 16'd3;
        repeat (3) tick();
        chk("pre_reset_ffff", {16'd0, led}, 32'h0000FFFF);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", {16'd0, led}, 32'h0);
        repeat (2) tick();
        chk("held_reset_led", {16'd0, led}, 32'h0);

        // Release with sw=3: flushed pipeline, reset addr 0 propagates, then ram[3].
        rst_n = 1'b1;
        tick();
        chk("rel_e0", {16'd0, led}, 32'h0);
        tick();
        chk("rel_e1", {16'd0, led}, 32'h00000001);
        tick();
        chk("rel_e2_ffff", {16'd0, led}, 32'h0000FFFF);
        tick();
        chk("rel_e3_ffff", {16'd0, led}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
